imem_loader: RTL and testbench

- Byte-stream program loader; the write side of the instruction memory that the CPU fetch stage reads.
- Receives a length header plus little-endian 32-bit instruction words over a valid/ready byte interface, and writes them to consecutive word-aligned instruction-memory addresses starting at 0.
- Holds the CPU in reset until the load completes, then releases it.
- Sits between the host/UART byte source and the instruction-memory write port, beside the cpu top.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/byte_packer.sv | 26 ++
 rtl/imem_loader.sv | 109 ++++++++++
 tb/tb_imem_loader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

   localparam int WORD_BYTES = 4;
   localparam int COUNT_W    = 16;

   typedef enum logic [2:0] {
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_WRITE,
      S_RUN,
      S_ERR
   } state_t;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        shift_en,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic [1:0]  byte_idx
);

   always_ff @(posedge clk) begin
      if (reset) begin
         word     <= '0;
         byte_idx <= '0;
      end else if (clear) begin
         byte_idx <= '0;
      end else if (shift_en) begin
         word[8*byte_idx +: 8] <= byte_in;
         byte_idx              <= byte_idx + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams a length header plus little-endian words into instruction memory,
// holding the CPU in reset until the whole program has been written.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter  int DEPTH  = 1024,
   localparam int ADDR_W = $clog2(DEPTH) + 2
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              err
);

   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   state_t               state, next_state;
   logic [COUNT_W-1:0]   count;
   logic [COUNT_W-1:0]   word_idx;
   logic [COUNT_W-1:0]   hdr_count;
   logic [31:0]          pk_word;
   logic [1:0]           pk_idx;
   logic                 xfer;
   logic                 last_byte;

   assign xfer      = in_valid && in_ready;
   assign hdr_count = {count[COUNT_W-1:8], in_data};
   assign last_byte = (state == S_DATA) && xfer && (pk_idx == 2'(WORD_BYTES - 1));

   byte_packer u_packer (
      .clk      (clk),
      .reset    (reset),
      .shift_en ((state == S_DATA) && xfer),
      .clear    (state == S_WRITE),
      .byte_in  (in_data),
      .word     (pk_word),
      .byte_idx (pk_idx)
   );

   always_comb begin
      next_state = state;
      unique case (state)
         S_LEN0:  if (xfer) next_state = S_LEN1;
         S_LEN1: begin
            if (xfer) begin
               if (hdr_count == '0)
                  next_state = S_RUN;
               else if (32'(hdr_count) > DEPTH_U)
                  next_state = S_ERR;
               else
                  next_state = S_DATA;
            end
         end
         S_DATA:  if (last_byte) next_state = S_WRITE;
         S_WRITE: next_state = ((word_idx + COUNT_W'(1)) == count) ? S_RUN : S_DATA;
         S_RUN:   next_state = S_RUN;
         S_ERR:   next_state = S_ERR;
         default: next_state = S_LEN0;
      endcase
   end

   // Status outputs are forced to their reset values while reset is asserted.
   always_comb begin
      in_ready  = 1'b0;
      imem_we   = 1'b0;
      cpu_reset = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      if (!reset) begin
         in_ready  = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);
         imem_we   = (state == S_WRITE);
         cpu_reset = (state != S_RUN);
         done      = (state == S_RUN);
         err       = (state == S_ERR);
      end
   end

   // Address and data are captured with the final byte so they are valid during the write cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_LEN0;
         count      <= '0;
         word_idx   <= '0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         state <= next_state;
         if (state == S_LEN0 && xfer)
            count[COUNT_W-1:8] <= in_data;
         if (state == S_LEN1 && xfer)
            count[7:0] <= in_data;
         if (last_byte) begin
            imem_addr  <= {word_idx[ADDR_W-3:0], 2'b00};
            imem_wdata <= (pk_word & 32'h00FF_FFFF) | {in_data, 24'h0};
         end
         if (state == S_WRITE)
            word_idx <= word_idx + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader; expected writes come from parsing the sent byte stream.
module tb_imem_loader;

   localparam int DEPTH  = 1024;
   localparam int ADDR_W = $clog2(DEPTH) + 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_reset;
   logic              done;
   logic              err;

   imem_loader #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   int         total = 0;
   int         bad   = 0;
   int         wrCount = 0;
   bit         watchCpuReset = 1'b0;
   logic       prevWe = 1'b0;
   wr_t        expQ[$];
   wr_t        popped;
   logic [7:0] stream[$];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Every write the DUT makes must match the next entry the model predicted.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wrCount++;
         checkOutput("we_single", 32'(prevWe), 32'd0);
         if (expQ.size() == 0)
            checkOutput("we_unexpected", 32'(imem_we), 32'd0);
         else begin
            popped = expQ.pop_front();
            checkOutput("wr_addr", 32'(imem_addr), popped.addr);
            checkOutput("wr_data", imem_wdata, popped.data);
         end
      end
      if (watchCpuReset)
         checkOutput("cpu_reset_held", 32'(cpu_reset), 32'd1);
      prevWe = imem_we;
   end

   // Reference model: header is a big-endian count, each following group of four bytes is a little-endian word.
   task automatic buildExpected();
      int  cnt;
      int  b;
      wr_t w;
      cnt = int'(stream[0]) * 256 + int'(stream[1]);
      if (cnt <= DEPTH) begin
         for (int i = 0; i < cnt; i++) begin
            b = 2 + 4 * i;
            if (b + 3 < stream.size()) begin
               w.addr = 32'(4 * i);
               w.data = 32'd0;
               for (int k = 0; k < 4; k++)
                  w.data = w.data + (32'(stream[b + k]) << (8 * k));
               expQ.push_back(w);
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      #1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready)
         checkOutput("ready_timeout", 32'(in_ready), 32'd1);
      else
         @(posedge clk);
   endtask

   task automatic sendStream(input int maxGap);
      int gap;
      buildExpected();
      for (int i = 0; i < stream.size(); i++) begin
         gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
         if (i >= 6 && ((i - 2) % 4) == 0)
            gap = 0;
         applyStimulus(stream[i], gap);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      #1;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      expQ.delete();
      wrCount = 0;
      #1;
      checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("post_rst_done", 32'(done), 32'd0);
      checkOutput("post_rst_err", 32'(err), 32'd0);
   endtask

   task automatic randomStream(input int cnt);
      stream.delete();
      stream.push_back(8'(cnt >> 8));
      stream.push_back(8'(cnt));
      for (int i = 0; i < 4 * cnt; i++)
         stream.push_back(8'($urandom));
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cnt;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      doReset();
      checkOutput("rst_addr", 32'(imem_addr), 32'd0);
      checkOutput("rst_wdata", imem_wdata, 32'd0);
      checkOutput("rst_we", 32'(imem_we), 32'd0);

      // Basic two-word load with timing of the release.
      stream = '{8'h00, 8'h02, 8'h21, 8'h04, 8'h00, 8'h91, 8'hC0, 8'h03, 8'h5F, 8'hD6};
      sendStream(0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checkOutput("basic_we_n1", 32'(imem_we), 32'd1);
      checkOutput("basic_cpurst_n1", 32'(cpu_reset), 32'd1);
      checkOutput("basic_done_n1", 32'(done), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("basic_cpurst_n2", 32'(cpu_reset), 32'd0);
      checkOutput("basic_done_n2", 32'(done), 32'd1);
      checkOutput("basic_ready_n2", 32'(in_ready), 32'd0);
      checkOutput("basic_wdata", imem_wdata, 32'hD65F03C0);
      checkOutput("basic_writes", 32'(wrCount), 32'd2);
      checkOutput("basic_left", 32'(expQ.size()), 32'd0);

      // Run lock: bytes offered after completion are ignored.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         #1;
         checkOutput("lock_ready", 32'(in_ready), 32'd0);
         checkOutput("lock_cpurst", 32'(cpu_reset), 32'd0);
         checkOutput("lock_done", 32'(done), 32'd1);
      end
      idle(2);
      checkOutput("lock_writes", 32'(wrCount), 32'd2);

      // Zero count releases the CPU straight after the header.
      doReset();
      stream = '{8'h00, 8'h00};
      sendStream(0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checkOutput("zero_cpurst", 32'(cpu_reset), 32'd0);
      checkOutput("zero_done", 32'(done), 32'd1);
      idle(3);
      checkOutput("zero_writes", 32'(wrCount), 32'd0);

      // Backpressure: random gaps, a byte is waiting during every write cycle.
      doReset();
      randomStream(3);
      sendStream(5);
      idle(3);
      checkOutput("bp_writes", 32'(wrCount), 32'd3);
      checkOutput("bp_left", 32'(expQ.size()), 32'd0);
      checkOutput("bp_last_addr", 32'(imem_addr), 32'd8);
      checkOutput("bp_done", 32'(done), 32'd1);

      // Overflow header 0x0401 is rejected.
      doReset();
      stream = '{8'h04, 8'h01};
      sendStream(0);
      @(negedge clk);
      in_data = 8'hAA;
      #1;
      checkOutput("ovf_err", 32'(err), 32'd1);
      checkOutput("ovf_ready", 32'(in_ready), 32'd0);
      checkOutput("ovf_cpurst", 32'(cpu_reset), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         checkOutput("ovf_err_sticky", 32'(err), 32'd1);
         checkOutput("ovf_cpurst_held", 32'(cpu_reset), 32'd1);
      end
      checkOutput("ovf_writes", 32'(wrCount), 32'd0);
      doReset();
      checkOutput("ovf_err_cleared", 32'(err), 32'd0);

      // Reset part-way through the second word, then a fresh one-word load.
      watchCpuReset = 1'b1;
      stream.delete();
      stream = '{8'h00, 8'h02};
      for (int i = 0; i < 6; i++)
         stream.push_back(8'($urandom));
      sendStream(2);
      idle(2);
      checkOutput("mid_writes", 32'(wrCount), 32'd1);
      checkOutput("mid_left", 32'(expQ.size()), 32'd0);
      doReset();
      stream = '{8'h00, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      sendStream(0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      watchCpuReset = 1'b0;
      checkOutput("mid_we", 32'(imem_we), 32'd1);
      checkOutput("mid_wdata", imem_wdata, 32'hDEADBEEF);
      checkOutput("mid_addr", 32'(imem_addr), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("mid_cpurst_release", 32'(cpu_reset), 32'd0);

      // Random short programs with random pacing.
      for (int t = 0; t < 4; t++) begin
         doReset();
         cnt = int'($urandom_range(1, 8));
         randomStream(cnt);
         sendStream(3);
         idle(3);
         checkOutput("rnd_writes", 32'(wrCount), 32'(cnt));
         checkOutput("rnd_left", 32'(expQ.size()), 32'd0);
         checkOutput("rnd_done", 32'(done), 32'd1);
      end

      // Full-capacity load ends at the last word address.
      doReset();
      randomStream(DEPTH);
      sendStream(0);
      idle(3);
      checkOutput("full_writes", 32'(wrCount), 32'(DEPTH));
      checkOutput("full_left", 32'(expQ.size()), 32'd0);
      checkOutput("full_last_addr", 32'(imem_addr), 32'(4 * (DEPTH - 1)));
      checkOutput("full_done", 32'(done), 32'd1);
      checkOutput("full_err", 32'(err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
